uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial receiver for the SOC UART link; the receive-side counterpart of the existing 8N1 emitter UART.
- Deserialises an 8N1 asynchronous line into bytes and buffers them in a small FIFO.
- Exposes a valid/ready byte stream plus sticky error flags, for mapping into the IO page.
- Intended map: a new one-hot word-address bit for data; status flags on the UART control register.

Parameters:
- clk_freq_hz, 100000000, CPU clock frequency in Hz.
- baud_rate, 1000000, line bit rate. DIV = clk_freq_hz/baud_rate (integer division); DIV must be >= 4.
- FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk, in, 1, CPU clock.
- reset, in, 1, synchronous, active-high.
- i_uart_rx, in, 1, asynchronous serial line; idles high.
- o_data, out, 8, byte at FIFO head.
- o_valid, out, 1, FIFO non-empty.
- i_ready, in, 1, pops the head when o_valid & i_ready.
- i_clr_err, in, 1, one-cycle pulse; clears all sticky flags.
- o_overrun, out, 1, sticky: a byte was dropped because the FIFO was full.
- o_frame_err, out, 1, sticky: a stop bit sampled low.
- o_parity_err, out, 1, sticky parity error (see Optional Feature).

Behaviour:
- Interface decision: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Reset values:
  - all outputs 0; o_data 0.
  - FIFO emptied; FSM in IDLE; bit counter and baud counter 0; synchroniser flops set to 1.
- Synchroniser: i_uart_rx passes through 2 flops; rx_s is the second flop output. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s==0, load baud counter with DIV/2 - 1, go to START.
  - START: at counter 0, if rx_s==1 treat as a glitch and return to IDLE with no flag. Otherwise load DIV-1, go to DATA, bit index 0.
  - DATA: at each counter 0, shift rx_s into bit[index] (LSB first) and reload DIV-1. After index 7, go to STOP.
  - STOP, rx_s==1 at counter 0: push the byte and go to IDLE.
  - STOP, rx_s==0 at counter 0: set o_frame_err, discard the byte, go to IDLE. The receiver re-arms only once rx_s is seen high in IDLE, so a break does not retrigger.
- Latency:
  - o_valid rises the cycle after the stop-bit sample when the FIFO was empty.
  - o_data is registered head data, valid whenever o_valid=1.
- FIFO:
  - Pointers are FIFO_DEPTH_LOG2+1 bits wide and wrap naturally; full/empty come from the MSB compare.
  - Push while full with no pop: byte dropped, o_overrun set, contents unchanged.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
  - Pop while empty: ignored.
  - Simultaneous push and pop while empty: the push lands and o_valid=1 next cycle.
- Flags:
  - Sticky until reset or i_clr_err.
  - If a set event and i_clr_err occur in the same cycle, set wins.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE next cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A parity state sits between DATA and STOP; the frame becomes 8E1.
  - The received parity bit must equal the XOR of the data bits.
  - Mismatch: set o_parity_err and discard the byte. The stop bit is still checked so framing stays synchronised.
- Undefined: 8N1 frames only; o_parity_err is tied to 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding constants.
  - DATA_BITS=8.
  - Helper function for the DIV computation.
- One sub-module, uart_rx_fifo: parameterised synchronous FIFO with push/pop/full/empty and registered head. The FSM stays in uart_receiver.

Test Plan (bench: clk_freq_hz=10000000, baud_rate=1000000, so DIV=10, depth 4):
- Single byte: drive 0x55 as 8N1 at 10 clk/bit with i_ready=0. o_valid rises 1 cycle after the stop sample with o_data=0x55; pulse i_ready and o_valid drops.
- Back-to-back: send 0x00, 0xFF, 0xA5, 0x3C with no gap. The FIFO returns them in order and o_overrun stays 0.
- Overrun: send 5 bytes 0x01..0x05 with i_ready=0. The FIFO holds 0x01..0x04 and o_overrun=1. i_clr_err clears it; a set event in the same cycle as i_clr_err keeps it 1.
- Framing: send 0x81 with the stop bit low for 2 bit times. Result: o_frame_err=1, no push, no retrigger until the line returns high; a following 0x42 is received correctly.
- Glitch/reset:
  - A 3-cycle low pulse on the idle line gives no push and no flags.
  - Asserting reset during bit 4 of 0x7E gives no push; the next clean byte 0x7E is received.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong). Result: o_parity_err=1 and no push; the correct parity bit 1 gives a push of 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry, FSM states
// and the clock-to-baud divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // PARITY is only entered when the receiver is built with UART_RX_PARITY_EN.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // Clocks per bit, truncated. The receiver needs at least 4 for a sane mid-bit sample.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte stream and sticky status between the UART receiver (master) and its
// consumer on the IO page (slave).
interface uart_receiver_if;

  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       i_clr_err;
  logic       o_overrun;
  logic       o_frame_err;
  logic       o_parity_err;

  modport master (
    output o_data, o_valid, o_overrun, o_frame_err, o_parity_err,
    input  i_ready, i_clr_err
  );

  modport slave (
    input  o_data, o_valid, o_overrun, o_frame_err, o_parity_err,
    output i_ready, i_clr_err
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a registered head word. Pointers carry one extra
// wrap bit so full and empty fall out of a single compare.
module uart_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = ((wr_q ^ rd_q) == FULL_XOR);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q + PTR_W'(do_push);
    rd_d = rd_q + PTR_W'(do_pop);
    // The new head is being written right now when it lands in the slot rd_d points to.
    if (do_push && (wr_q == rd_d)) head_d = din_i;
    else                           head_d = mem_q[rd_d[DEPTH_LOG2-1:0]];
  end

  // NOTE: storage has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[DEPTH_LOG2-1:0]] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive o_parity_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_freq_hz     = 100000000,
  parameter int baud_rate       = 1000000,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_uart_rx,
  uart_receiver_if.master bus
);

  localparam int DIV   = calc_div(clk_freq_hz, baud_rate);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 ovr_q, ovr_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s, rx_push, frame_set, ovr_set;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 par_ok_q, par_ok_d;
  logic                 perr_q, perr_d;
  logic                 par_set;
`endif

  assign rx_s = sync_q[1];

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q | rx_s;
    rx_push   = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d  = par_ok_q;
    par_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = ST_START;
          cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
        else if (rx_s)    state_d = ST_IDLE;
        else begin
          state_d = ST_DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = CNT_FULL;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          par_ok_d = (rx_s == ^shift_q);
          par_set  = (rx_s != ^shift_q);
          cnt_d    = CNT_FULL;
          state_d  = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d = ST_IDLE;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            rx_push = par_ok_q;
`else
            rx_push = 1'b1;
`endif
          end else begin
            // A low stop bit may be a break; wait for the line to go high first.
            frame_set = 1'b1;
            armed_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set wins over a simultaneous clear; a full FIFO drops the byte unless it pops now.
  assign ovr_set = rx_push & fifo_full & ~bus.i_ready;
  assign ovr_d   = (ovr_q & ~bus.i_clr_err) | ovr_set;
  assign ferr_d  = (ferr_q & ~bus.i_clr_err) | frame_set;
`ifdef UART_RX_PARITY_EN
  assign perr_d  = (perr_q & ~bus.i_clr_err) | par_set;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      armed_q  <= 1'b1;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      sync_q   <= {sync_q[0], i_uart_rx};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q <= par_ok_d;
      perr_q   <= perr_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH      (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .din_i   (shift_q),
    .pop_i   (bus.i_ready),
    .head_o  (bus.o_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.o_valid     = ~fifo_empty;
  assign bus.o_overrun   = ovr_q;
  assign bus.o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = perr_q;
`else
  assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model (byte queue + sticky
// flags driven by scheduled frame outcomes) compared every cycle, plus literal pins.
module tb_uart_receiver;

  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Line falls just before posedge 1: two sync flops plus the IDLE decision take three edges,
  // the sample point sits half a bit in, and each further bit adds DIV.
  localparam int T_PAR  = 3 + DIV / 2 + 9 * DIV;
  localparam int T_STOP = 3 + DIV / 2 + (9 + PBITS) * DIV;

  typedef enum int {EV_PUSH, EV_FERR, EV_PERR} ev_kind_e;
  typedef struct {
    int         t;
    ev_kind_e   kind;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;

  uart_receiver_if bus();

  uart_receiver #(
    .clk_freq_hz     (CLK_HZ),
    .baud_rate       (BAUD),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_uart_rx (rx),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         cmp_en = 1'b0;
  logic [7:0] mq[$];
  bit         m_ov, m_fe, m_pe;
  ev_t        evq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: apply the handshake pop, then any frame outcomes due at this edge.
  always @(posedge clk) begin : model
    bit  s_ov, s_fe, s_pe;
    ev_t keep[$];
    cyc++;
    s_ov = 1'b0; s_fe = 1'b0; s_pe = 1'b0;
    keep.delete();
    if (reset) begin
      mq.delete();
      evq.delete();
      m_ov = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
      cmp_en = 1'b1;
    end else begin
      if (bus.i_ready && mq.size() > 0) void'(mq.pop_front());
      foreach (evq[i]) begin
        if (evq[i].t == cyc) begin
          case (evq[i].kind)
            EV_PUSH: if (mq.size() < DEPTH) mq.push_back(evq[i].d); else s_ov = 1'b1;
            EV_FERR: s_fe = 1'b1;
            default: s_pe = 1'b1;
          endcase
        end else keep.push_back(evq[i]);
      end
      evq  = keep;
      m_ov = (m_ov & ~bus.i_clr_err) | s_ov;
      m_fe = (m_fe & ~bus.i_clr_err) | s_fe;
      m_pe = (m_pe & ~bus.i_clr_err) | s_pe;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(bus.o_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("data", 32'(bus.o_data), 32'(mq[0]));
      check("overrun", 32'(bus.o_overrun), 32'(m_ov));
      check("frame_err", 32'(bus.o_frame_err), 32'(m_fe));
      check("parity_err", 32'(bus.o_parity_err), 32'(m_pe));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; stop_low>0 replaces the stop bit by that many low bit times.
  task automatic send_frame(input logic [7:0] d, input int stop_low = 0,
                            input bit bad_par = 1'b0, input int clr_k = -1);
    logic bits[$];
    int   start;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (PBITS == 1) bits.push_back((^d) ^ bad_par);
    if (stop_low > 0) repeat (stop_low) bits.push_back(1'b0);
    else bits.push_back(1'b1);
    @(negedge clk);
    start = cyc;
    if (PBITS == 1 && bad_par) evq.push_back('{start + T_PAR, EV_PERR, d});
    if (stop_low > 0) evq.push_back('{start + T_STOP, EV_FERR, d});
    else if (!(PBITS == 1 && bad_par)) evq.push_back('{start + T_STOP, EV_PUSH, d});
    for (int k = 0; k < bits.size() * DIV; k++) begin
      if (k > 0) @(negedge clk);
      rx            = bits[k / DIV];
      bus.i_clr_err = (k == clr_k);
    end
  endtask

  task automatic clear_flags();
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] b2b [4];
    logic [7:0] d7e;
    b2b = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    d7e = 8'h7E;
    bus.i_ready   = 1'b0;
    bus.i_clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_data", 32'(bus.o_data), 32'h0);
    check("rst_overrun", 32'(bus.o_overrun), 32'h0);
    check("rst_frame_err", 32'(bus.o_frame_err), 32'h0);
    check("rst_parity_err", 32'(bus.o_parity_err), 32'h0);
    reset = 1'b0;
    idle(5);

    // Single byte, then a one-cycle pop.
    send_frame(8'h55);
    check("single_valid", 32'(bus.o_valid), 32'h1);
    check("single_data", 32'(bus.o_data), 32'h55);
    @(negedge clk); bus.i_ready = 1'b1;
    @(negedge clk); bus.i_ready = 1'b0;
    check("single_popped", 32'(bus.o_valid), 32'h0);

    // Back-to-back frames with no idle gap.
    idle(5);
    foreach (b2b[i]) send_frame(b2b[i]);
    idle(2);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_data", 32'(bus.o_data), 32'(b2b[i]));
      @(negedge clk);
    end
    bus.i_ready = 1'b0;
    check("b2b_empty", 32'(bus.o_valid), 32'h0);
    check("b2b_no_overrun", 32'(bus.o_overrun), 32'h0);

    // Overrun: fifth byte dropped; clear; set coincident with clear wins.
    idle(5);
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    idle(2);
    check("ovr_flag", 32'(bus.o_overrun), 32'h1);
    check("ovr_head", 32'(bus.o_data), 32'h01);
    clear_flags();
    check("ovr_cleared", 32'(bus.o_overrun), 32'h0);
    send_frame(8'h06, 0, 1'b0, T_STOP - 1);
    idle(2);
    check("ovr_set_wins", 32'(bus.o_overrun), 32'h1);
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovr_data", 32'(bus.o_data), 32'(i));
      @(negedge clk);
    end
    bus.i_ready = 1'b0;
    check("ovr_drained", 32'(bus.o_valid), 32'h0);
    clear_flags();

    // Framing error with a long low stop; no retrigger until the line is high.
    idle(5);
    send_frame(8'h81, 2);
    check("frame_flag", 32'(bus.o_frame_err), 32'h1);
    check("frame_no_push", 32'(bus.o_valid), 32'h0);
    @(negedge clk); rx = 1'b1;
    idle(150);
    check("frame_no_retrigger", 32'(bus.o_valid), 32'h0);
    send_frame(8'h42);
    check("frame_next_data", 32'(bus.o_data), 32'h42);
    @(negedge clk); bus.i_ready = 1'b1;
    @(negedge clk); bus.i_ready = 1'b0;
    clear_flags();
    check("frame_cleared", 32'(bus.o_frame_err), 32'h0);

    // Short glitch on the idle line.
    idle(5);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(150);
    check("glitch_no_push", 32'(bus.o_valid), 32'h0);
    check("glitch_no_flag", 32'(bus.o_frame_err), 32'h0);

    // Reset during bit 4, then a clean frame.
    for (int k = 0; k < 5 * DIV + 5; k++) begin
      @(negedge clk);
      rx = (k < DIV) ? 1'b0 : d7e[k / DIV - 1];
    end
    @(negedge clk); reset = 1'b1; rx = 1'b1;
    @(negedge clk); reset = 1'b0;
    idle(30);
    check("rst_mid_no_push", 32'(bus.o_valid), 32'h0);
    send_frame(8'h7E);
    check("rst_mid_next_data", 32'(bus.o_data), 32'h7E);
    @(negedge clk); bus.i_ready = 1'b1;
    @(negedge clk); bus.i_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
    // Wrong parity discards the byte; correct parity delivers it.
    idle(5);
    send_frame(8'h07, 0, 1'b1);
    check("par_flag", 32'(bus.o_parity_err), 32'h1);
    check("par_no_push", 32'(bus.o_valid), 32'h0);
    send_frame(8'h07);
    check("par_good_valid", 32'(bus.o_valid), 32'h1);
    check("par_good_data", 32'(bus.o_data), 32'h07);
    @(negedge clk); bus.i_ready = 1'b1;
    @(negedge clk); bus.i_ready = 1'b0;
    clear_flags();
`endif

    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
